puf_challenge_ctrl: RTL and testbench

//  Sequencer for the ring-oscillator PUF core (oscillator bank + two edge counters + muxes).

---
 rtl/puf_challenge_ctrl.sv | 108 ++++++++++
 tb/tb_puf_challenge_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - ring-oscillator PUF challenge sequencer
// Runs one oscillator-pair race per response bit and hands the response word out over valid/ready.
module puf_challenge_ctrl #(
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*RESP_BITS-1:0] challenge,
  input  logic                   abort,
  output logic                   busy,
  output logic                   osc_en,
  output logic                   cnt_clr,
  output logic [1:0]             sel_a,
  output logic [1:0]             sel_b,
  input  logic [CNT_W-1:0]       cnt_a,
  input  logic [CNT_W-1:0]       cnt_b,
  output logic [RESP_BITS-1:0]   resp,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   sat_err
);

  localparam int PH_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [PH_W-1:0]  WIN_LAST = PH_W'(WINDOW - 1);
  localparam logic [PH_W-1:0]  SET_LAST = PH_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_COMPARE, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [PH_W-1:0]        ph_cnt;
  logic [IDX_W-1:0]       idx;
  logic [4*RESP_BITS-1:0] chal_q;
  logic                   accept;
  logic                   aborting;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign aborting = (state != S_IDLE) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_RUN;
      S_RUN:     if (ph_cnt == WIN_LAST) state_nxt = S_SETTLE;
      S_SETTLE:  if (ph_cnt == SET_LAST) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = (idx == IDX_LAST) ? S_DONE : S_CLEAR;
      S_DONE:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (aborting) state_nxt = S_IDLE;
  end

  // The challenge register shifts one slice per bit so the live selects are always its low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt  <= '0;
      idx     <= '0;
      chal_q  <= '0;
      resp    <= '0;
      sat_err <= 1'b0;
    end else begin
      if ((state == S_RUN && state_nxt == S_RUN) ||
          (state == S_SETTLE && state_nxt == S_SETTLE))
        ph_cnt <= ph_cnt + PH_W'(1);
      else
        ph_cnt <= '0;

      if (accept) begin
        chal_q  <= challenge;
        resp    <= '0;
        sat_err <= 1'b0;
        idx     <= '0;
      end else if (aborting) begin
        resp <= '0;
        idx  <= '0;
      end else if (state == S_COMPARE) begin
        resp[idx] <= (cnt_a > cnt_b);
        if ((&cnt_a) || (&cnt_b)) sat_err <= 1'b1;
        if (idx != IDX_LAST) begin
          idx    <= idx + IDX_W'(1);
          chal_q <= chal_q >> 4;
        end
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign osc_en     = (state == S_RUN);
  assign cnt_clr    = (state == S_CLEAR);
  assign resp_valid = (state == S_DONE);
  assign sel_a      = busy ? chal_q[1:0] : 2'd0;
  assign sel_b      = busy ? chal_q[3:2] : 2'd0;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb/tb_puf_challenge_ctrl.sv - self-checking bench for puf_challenge_ctrl
// Oscillator bank modelled as four fixed frequencies; responses predicted from the challenge.
module tb_puf_challenge_ctrl;

  localparam int RB  = 8;
  localparam int WIN = 16;
  localparam int SET = 4;
  localparam int LAT = 1 + RB * (WIN + SET + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4*RB-1:0] challenge;
  logic          abort;
  logic          busy, osc_en, cnt_clr;
  logic [1:0]    sel_a, sel_b;
  logic [15:0]   cnt_a, cnt_b;
  logic [RB-1:0] resp;
  logic          resp_valid;
  logic          resp_ready;
  logic          sat_err;

  logic [15:0]   freq [4];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_osc   = 0;
  int            n_clr   = 0;

  puf_challenge_ctrl #(
    .RESP_BITS(RB), .CNT_W(16), .WINDOW(WIN), .SETTLE(SET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .abort(abort),
    .busy(busy), .osc_en(osc_en), .cnt_clr(cnt_clr), .sel_a(sel_a), .sel_b(sel_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .resp(resp), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    cnt_a = freq[sel_a];
    cnt_b = freq[sel_b];
  end

  always @(negedge clk) begin
    if (osc_en)  n_osc++;
    if (cnt_clr) n_clr++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] model_resp(input logic [4*RB-1:0] ch);
    logic [RB-1:0] r;
    for (int i = 0; i < RB; i++)
      r[i] = freq[ch[4*i +: 2]] > freq[ch[4*i+2 +: 2]];
    return r;
  endfunction

  function automatic logic model_sat(input logic [4*RB-1:0] ch);
    logic s = 1'b0;
    for (int i = 0; i < RB; i++)
      if (freq[ch[4*i +: 2]] == 16'hFFFF || freq[ch[4*i+2 +: 2]] == 16'hFFFF) s = 1'b1;
    return s;
  endfunction

  task automatic do_start(input logic [4*RB-1:0] ch);
    @(negedge clk);
    start     = 1'b1;
    challenge = ch;
    @(negedge clk);
    start     = 1'b0;
    challenge = $urandom();
  endtask

  // hold: cycles resp_ready stays low in DONE; kill: abort together with resp_ready in DONE
  task automatic eval(input logic [4*RB-1:0] ch, input int hold, input bit kill);
    logic [RB-1:0] exp_r;
    logic          exp_s;
    int            n, osc0, clr0, bad;
    exp_r = model_resp(ch);
    exp_s = model_sat(ch);
    osc0  = n_osc;
    clr0  = n_clr;
    do_start(ch);
    chk("sat_cleared_on_start", sat_err, 0);
    chk("busy_after_start", busy, 1);
    n = 1;
    while (!resp_valid && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    chk("resp", resp, exp_r);
    chk("sat_err", sat_err, exp_s);
    chk("osc_en_cycles", n_osc - osc0, RB * WIN);
    chk("cnt_clr_pulses", n_clr - clr0, RB);
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      start = (k % 3 == 1);
      @(negedge clk);
      if (!resp_valid || resp !== exp_r || sat_err !== exp_s) bad++;
    end
    start = 1'b0;
    if (hold > 0) chk("done_hold_stable", bad, 0);
    resp_ready = 1'b1;
    abort      = kill;
    @(negedge clk);
    resp_ready = 1'b0;
    abort      = 1'b0;
    chk("idle_after_handshake", {busy, resp_valid}, 2'b00);
    chk("resp_after_handshake", resp, kill ? '0 : exp_r);
  endtask

  task automatic rand_freq();
    for (int i = 0; i < 4; i++)
      freq[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4*RB-1:0] ch;
    int bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_ready = 1'b0; challenge = '0;
    for (int i = 0; i < 4; i++) freq[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, osc_en, cnt_clr, resp_valid, sat_err}, 5'b0);
    chk("reset_data", {sel_a, sel_b, resp}, '0);
    rst_n = 1'b1;

    // alternating oscillator pairs give the 0x55 pattern
    freq[0] = 16'd100; freq[1] = 16'd90; freq[2] = 16'd50; freq[3] = 16'd60;
    chk("model_0x55", model_resp(32'hE4E4E4E4), 8'h55);
    eval(32'hE4E4E4E4, 10, 1'b0);

    for (int i = 0; i < 4; i++) freq[i] = 16'd200;
    eval($urandom(), 0, 1'b0);

    rand_freq();
    ch = '0;
    for (int i = 0; i < RB; i++) begin
      ch[4*i +: 2]   = 2'($urandom_range(0, 3));
      ch[4*i+2 +: 2] = ch[4*i +: 2];
    end
    eval(ch, 2, 1'b0);

    // saturation only reachable through bit 2's sel_a
    freq[0] = 16'd10; freq[1] = 16'd20; freq[2] = 16'd30; freq[3] = 16'hFFFF;
    ch = '0;
    for (int i = 0; i < RB; i++) begin
      ch[4*i +: 2]   = (i == 2) ? 2'd3 : 2'($urandom_range(0, 2));
      ch[4*i+2 +: 2] = (i == 2) ? 2'd0 : 2'($urandom_range(0, 2));
    end
    eval(ch, 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rand_freq();
      eval($urandom(), $urandom_range(0, 4), (t == 5));
    end

    // abort in the fifth RUN cycle of bit 3
    rand_freq();
    ch = $urandom();
    do_start(ch);
    repeat (3 * (WIN + SET + 2) + 5) @(negedge clk);
    chk("abort_in_run", osc_en, 1);
    chk("abort_sel_a", sel_a, ch[13:12]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, osc_en, resp_valid}, 3'b000);
    chk("abort_resp", resp, 0);
    bad = 0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (resp_valid || busy) bad++;
    end
    chk("abort_no_valid", bad, 0);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);

    // asynchronous reset mid-RUN
    do_start($urandom());
    repeat (8) @(negedge clk);
    chk("pre_reset_run", osc_en, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run", {busy, osc_en, resp_valid}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
